// File: rtl/interval_timer_if.sv
// ---------------------------------------------------------------------------
// interval_timer_if : request/response bundle between FSM and interval_timer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface interval_timer_if;
   logic       start_timer;
   logic [1:0] requesting_interval;
   logic       reprogram;
   logic [1:0] time_param_select;
   logic [3:0] time_value;
   logic       expired;
   logic       busy;
   logic       second_tick;

   modport master (
      output start_timer, requesting_interval, reprogram, time_param_select, time_value,
      input  expired, busy, second_tick
   );

   modport slave (
      input  start_timer, requesting_interval, reprogram, time_param_select, time_value,
      output expired, busy, second_tick
   );
endinterface

`default_nettype wire

// File: rtl/interval_timer.sv
// ---------------------------------------------------------------------------
// interval_timer : programmable seconds countdown with one-cycle expiry pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module interval_timer #(
   parameter int unsigned CLK_DIV = 50_000_000,
   parameter logic [3:0]  T_BASE  = 4'd6,
   parameter logic [3:0]  T_EXT   = 4'd3,
   parameter logic [3:0]  T_YEL   = 4'd2
) (
   input  wire logic        clk,
   input  wire logic        reset,
   interval_timer_if.slave  bus
);

   localparam int unsigned     c_PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_PW-1:0] r_pre;
   logic [3:0]      r_sec;
   logic [3:0]      r_t_base;
   logic [3:0]      r_t_ext;
   logic [3:0]      r_t_yel;
   logic            r_expired;
   logic            r_busy;
   logic            r_tick;

   logic            w_start;
   logic            w_reprog;
   logic            w_wrap;
   logic            w_last;
   logic [3:0]      w_sel_val;
   logic [3:0]      w_load_val;
   logic            w_expired_nxt;
   logic            w_busy_nxt;
   logic            w_tick_nxt;

   // Reprogram has priority: a coincident start is dropped.
   always_comb begin
      w_reprog = bus.reprogram;
      w_start  = bus.start_timer & ~bus.reprogram;
      w_wrap   = (r_pre == c_PRE_MAX);
      w_last   = w_wrap && (r_sec <= 4'd1);
      case (bus.requesting_interval)
         2'b01:   w_sel_val = r_t_ext;
         2'b10:   w_sel_val = r_t_yel;
         default: w_sel_val = r_t_base;
      endcase
      w_load_val = (w_sel_val == 4'd0) ? 4'd1 : w_sel_val;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_COUNT;
         S_COUNT: if (!w_start && w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = w_start ? S_COUNT : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_reprog) w_state_nxt = S_IDLE;

      w_expired_nxt = (w_state_nxt == S_DONE);
      w_busy_nxt    = (w_state_nxt == S_COUNT);
      w_tick_nxt    = (r_state == S_COUNT) && w_wrap && !w_start && !w_reprog;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_expired <= 1'b0;
         r_busy    <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_expired <= w_expired_nxt;
         r_busy    <= w_busy_nxt;
         r_tick    <= w_tick_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre    <= '0;
         r_sec    <= 4'd0;
         r_t_base <= T_BASE;
         r_t_ext  <= T_EXT;
         r_t_yel  <= T_YEL;
      end else if (w_reprog) begin
         case (bus.time_param_select)
            2'b00:   r_t_base <= bus.time_value;
            2'b01:   r_t_ext  <= bus.time_value;
            2'b10:   r_t_yel  <= bus.time_value;
            default: ;
         endcase
         r_pre <= '0;
         r_sec <= 4'd0;
      end else if (w_start) begin
         r_pre <= '0;
         r_sec <= w_load_val;
      end else if (r_state == S_COUNT) begin
         r_pre <= w_wrap ? '0 : r_pre + c_PW'(1);
         // Seconds hold at 1 on the final wrap; the FSM leaves COUNT there.
         if (w_wrap && (r_sec > 4'd1)) r_sec <= r_sec - 4'd1;
      end
   end

   assign bus.expired     = r_expired;
   assign bus.busy        = r_busy;
   assign bus.second_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_interval_timer : directed bench for interval_timer with CLK_DIV = 4
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_interval_timer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   interval_timer_if bus_if ();

   interval_timer #(
      .CLK_DIV (4),
      .T_BASE  (4'd6),
      .T_EXT   (4'd3),
      .T_YEL   (4'd2)
   ) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // All stimulus tasks start and finish at a falling edge.
   task automatic start(input logic [1:0] code);
      bus_if.start_timer         = 1'b1;
      bus_if.requesting_interval = code;
      @(negedge clk);
      bus_if.start_timer         = 1'b0;
   endtask

   task automatic reprog(input logic [1:0] sel, input logic [3:0] val);
      bus_if.reprogram         = 1'b1;
      bus_if.time_param_select = sel;
      bus_if.time_value        = val;
      @(negedge clk);
      bus_if.reprogram         = 1'b0;
   endtask

   task automatic measure(input int limit, output int lat, output int ticks, output int gaps);
      lat   = -1;
      ticks = 0;
      gaps  = 0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (bus_if.expired) begin
            lat = k;
            break;
         end
         if (bus_if.second_tick) ticks++;
         if (!bus_if.busy) gaps++;
      end
   endtask

   task automatic expect_expiry(input string tag, input int exp_lat, input int exp_ticks);
      int lat, ticks, gaps;
      measure(exp_lat + 8, lat, ticks, gaps);
      check_value({tag, "_latency"}, lat, exp_lat);
      check_value({tag, "_ticks"}, ticks, exp_ticks);
      check_value({tag, "_busy_gaps"}, gaps, 0);
      check_value({tag, "_busy_at_expiry"}, int'(bus_if.busy), 0);
   endtask

   initial begin
      int lat, ticks, gaps, n_exp;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus_if.start_timer         = 1'b0;
      bus_if.requesting_interval = 2'b00;
      bus_if.reprogram           = 1'b0;
      bus_if.time_param_select   = 2'b11;
      bus_if.time_value          = 4'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_value("rst_expired", int'(bus_if.expired), 0);
      check_value("rst_busy", int'(bus_if.busy), 0);
      check_value("rst_tick", int'(bus_if.second_tick), 0);

      // Base interval 6 s -> 24 cycles
      start(2'b00);
      check_value("base_busy_start", int'(bus_if.busy), 1);
      expect_expiry("base", 24, 5);
      @(negedge clk);
      check_value("base_pulse_end", int'(bus_if.expired), 0);

      // Extended start aborted by yellow restart 6 cycles later
      start(2'b01);
      n_exp = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus_if.expired) n_exp++;
      end
      start(2'b10);
      check_value("restart_no_early_exp", n_exp, 0);
      expect_expiry("restart", 8, 1);
      measure(20, lat, ticks, gaps);
      check_value("restart_single_pulse", lat, -1);

      // Reprogram yellow to 5; select 11 must write nothing
      reprog(2'b10, 4'd5);
      start(2'b10);
      expect_expiry("yel5", 20, 4);
      @(negedge clk);
      reprog(2'b11, 4'd9);
      start(2'b00);
      expect_expiry("sel11_base", 24, 5);
      @(negedge clk);

      // Reprogram mid-count aborts
      start(2'b00);
      repeat (9) @(negedge clk);
      reprog(2'b11, 4'd1);
      check_value("abort_busy", int'(bus_if.busy), 0);
      measure(40, lat, ticks, gaps);
      check_value("abort_no_expiry", lat, -1);

      // Reprogram and start on the same edge: start ignored
      bus_if.start_timer = 1'b1;
      bus_if.requesting_interval = 2'b01;
      reprog(2'b01, 4'd4);
      bus_if.start_timer = 1'b0;
      check_value("collide_busy", int'(bus_if.busy), 0);
      start(2'b01);
      expect_expiry("ext4", 16, 3);
      @(negedge clk);

      // Base = 0 loads as 1 s; code 11 aliases base; start during DONE
      reprog(2'b00, 4'd0);
      start(2'b00);
      expect_expiry("base0", 4, 0);
      @(negedge clk);
      start(2'b11);
      expect_expiry("code11", 4, 0);
      start(2'b00);
      check_value("done_restart_busy", int'(bus_if.busy), 1);
      expect_expiry("done_restart", 4, 0);
      @(negedge clk);

      // Asynchronous reset mid-count
      reprog(2'b00, 4'd7);
      start(2'b00);
      repeat (4) @(negedge clk);
      check_value("pre_reset_tick", int'(bus_if.second_tick), 1);
      #1 rst_n = 1'b0;
      #1;
      check_value("async_tick", int'(bus_if.second_tick), 0);
      check_value("async_busy", int'(bus_if.busy), 0);
      n_exp = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus_if.expired || bus_if.busy) n_exp++;
      end
      check_value("reset_hold_quiet", n_exp, 0);
      rst_n = 1'b1;
      measure(40, lat, ticks, gaps);
      check_value("reset_no_late_expiry", lat, -1);
      start(2'b10);
      expect_expiry("reset_yel", 8, 1);
      @(negedge clk);
      start(2'b01);
      expect_expiry("reset_ext", 12, 2);
      @(negedge clk);
      start(2'b00);
      expect_expiry("reset_base", 24, 5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
